// File: rtl/sarray_storec_pkg.sv
// -----------------------------------------------------------------------------
// sarray_storec_pkg
// Shared definitions for the systolic-array store-C write-back stage:
//   - TINST_TYPE_STOREC : instruction type encoding for TSTOREC
//   - SARRAY_STORE_WIDTH: row width delivered by the array store port
//   - TMMA_CNT_WIDTH    : row index width (ROWS = 2**TMMA_CNT_WIDTH)
//   - ADDR_WIDTH        : memory address width
//   - storec_state_t    : write-back controller state encoding
// -----------------------------------------------------------------------------
package sarray_storec_pkg;

  localparam logic [3:0] TINST_TYPE_STOREC  = 4'h6;
  localparam int         SARRAY_STORE_WIDTH = 256;
  localparam int         TMMA_CNT_WIDTH     = 6;
  localparam int         ADDR_WIDTH         = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2
  } storec_state_t;

endpackage

// File: rtl/sarray_storec_sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Small single-clock FIFO used as the row buffer of sarray_storec.
// The head entry is read straight out of registered storage, so there is no
// combinational path from push_data_i to head_o.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset (empties the FIFO)
//   push_i       : write request; ignored when full unless popping this cycle
//   push_data_i  : write data
//   pop_i        : read request; ignored when empty
//   full_o       : all DEPTH entries occupied
//   empty_o      : no entries occupied
//   head_o       : oldest entry (valid when !empty_o)
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  logic w_do_push;
  logic w_do_pop;

  assign full_o  = (r_count == (PTR_W+1)'(DEPTH));
  assign empty_o = (r_count == '0);

  assign w_do_pop  = pop_i && !empty_o;
  // A push into a full FIFO is accepted only when a pop frees a slot in the
  // same cycle; otherwise it is dropped.
  assign w_do_push = push_i && (!full_o || w_do_pop);

  assign head_o = r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= push_data_i;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + (PTR_W+1)'(1);
      end else if (!w_do_push && w_do_pop) begin
        r_count <= r_count - (PTR_W+1)'(1);
      end
    end
  end

endmodule

// File: rtl/sarray_storec.sv
// -----------------------------------------------------------------------------
// sarray_storec
// Write-back stage behind the systolic array. A TSTOREC instruction makes the
// block request accumulator rows one at a time, buffer the returned rows and
// write each one to memory over the aw channel. Requests are gated by a credit
// counter equal to free buffer space, so the array (which has no backpressure)
// can never overrun the buffer.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   storec_valid_i/ready_o, storec_addr_i : instruction handshake, base address
//   post_storec_valid_o  : one-cycle request for one row from the array
//   bot_valid_i/cnt_i/data_i : returned row, its index and data
//   aw_valid_o/ready_i, aw_addr_o, aw_data_o : memory write channel
//   busy_o               : not idle
//   done_o               : pulse after the last row's write is accepted
//   err_o                : sticky protocol error (row order / overflow)
// -----------------------------------------------------------------------------
module sarray_storec #(
  parameter int ADDR_WIDTH = sarray_storec_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = sarray_storec_pkg::SARRAY_STORE_WIDTH,
  parameter int CNT_WIDTH  = sarray_storec_pkg::TMMA_CNT_WIDTH,
  parameter int FIFO_DEPTH = 4,
  parameter int ROW_SHIFT  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  storec_valid_i,
  output logic                  storec_ready_o,
  input  logic [ADDR_WIDTH-1:0] storec_addr_i,
  output logic                  post_storec_valid_o,
  input  logic                  bot_valid_i,
  input  logic [CNT_WIDTH-1:0]  bot_cnt_i,
  input  logic [DATA_WIDTH-1:0] bot_data_i,
  output logic                  aw_valid_o,
  input  logic                  aw_ready_i,
  output logic [ADDR_WIDTH-1:0] aw_addr_o,
  output logic [DATA_WIDTH-1:0] aw_data_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  import sarray_storec_pkg::*;

  localparam int                     CREDIT_WIDTH = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CREDIT_WIDTH-1:0] CREDIT_FULL = CREDIT_WIDTH'(FIFO_DEPTH);
  localparam logic [CNT_WIDTH-1:0]    LAST_ROW    = '1;
  localparam int                     ENTRY_WIDTH  = CNT_WIDTH + DATA_WIDTH;

  storec_state_t           r_state;
  logic [ADDR_WIDTH-1:0]   r_base;
  logic [CNT_WIDTH-1:0]    r_req_cnt;
  logic [CNT_WIDTH-1:0]    r_exp_cnt;
  logic [CNT_WIDTH-1:0]    r_wr_cnt;
  logic [CREDIT_WIDTH-1:0] r_credit;
  logic                    r_done;
  logic                    r_err;

  logic                    w_accept;
  logic                    w_post;
  logic                    w_pop;
  logic                    w_credit_ret;
  logic                    w_full;
  logic                    w_empty;
  logic [ENTRY_WIDTH-1:0]  w_head;
  logic [CNT_WIDTH-1:0]    w_head_cnt;
  logic [ADDR_WIDTH-1:0]   w_row_offset;

  assign w_accept = storec_valid_i && (r_state == ST_IDLE);
  // Posts depend only on registered state and credit.
  assign w_post   = (r_state == ST_DRAIN) && (r_credit != '0);
  assign w_pop    = !w_empty && aw_ready_i;
  // Credit only comes back while a store is in progress; stray rows written
  // while idle must not push credit above the buffer size.
  assign w_credit_ret = w_pop && (r_state != ST_IDLE);

  sync_fifo #(
    .WIDTH (ENTRY_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (bot_valid_i),
    .push_data_i ({bot_cnt_i, bot_data_i}),
    .pop_i       (w_pop),
    .full_o      (w_full),
    .empty_o     (w_empty),
    .head_o      (w_head)
  );

  assign w_head_cnt   = w_head[DATA_WIDTH +: CNT_WIDTH];
  // Row offset computed at address width; carries past the top bit drop.
  assign w_row_offset = ADDR_WIDTH'(w_head_cnt) << ROW_SHIFT;

  assign storec_ready_o      = (r_state == ST_IDLE);
  assign busy_o              = (r_state != ST_IDLE);
  assign post_storec_valid_o = w_post;
  assign aw_valid_o          = !w_empty;
  assign aw_addr_o           = r_base + w_row_offset;
  assign aw_data_o           = w_head[DATA_WIDTH-1:0];
  assign done_o              = r_done;
  assign err_o               = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_base    <= '0;
      r_req_cnt <= '0;
      r_exp_cnt <= '0;
      r_wr_cnt  <= '0;
      r_credit  <= CREDIT_FULL;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done <= 1'b0;

      if (w_post) begin
        r_req_cnt <= r_req_cnt + CNT_WIDTH'(1);
      end

      // Rows are accepted in any state; out-of-order tags and overflow
      // (full with no simultaneous pop) both raise the sticky error.
      if (bot_valid_i) begin
        r_exp_cnt <= r_exp_cnt + CNT_WIDTH'(1);
        if ((bot_cnt_i != r_exp_cnt) || (w_full && !w_pop)) begin
          r_err <= 1'b1;
        end
      end

      if (w_pop) begin
        r_wr_cnt <= r_wr_cnt + CNT_WIDTH'(1);
      end

      if (w_post && !w_credit_ret) begin
        r_credit <= r_credit - CREDIT_WIDTH'(1);
      end else if (!w_post && w_credit_ret) begin
        r_credit <= r_credit + CREDIT_WIDTH'(1);
      end

      // State transitions; the accept branch overrides counter updates above.
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state   <= ST_DRAIN;
            r_base    <= storec_addr_i;
            r_req_cnt <= '0;
            r_exp_cnt <= '0;
            r_wr_cnt  <= '0;
            r_credit  <= CREDIT_FULL;
          end
        end
        ST_DRAIN: begin
          if (w_post && (r_req_cnt == LAST_ROW)) begin
            r_state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (w_pop && (r_wr_cnt == LAST_ROW)) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
